// File: rtl/flash_write_sequencer_if.sv
// Command channel between the write sequencer and the SPI flash controller.
// The sequencer drives commands; the controller answers with ctrl_busy.
interface flash_write_sequencer_if;
  logic        ctrl_write;
  logic        ctrl_erase;
  logic [23:0] ctrl_address;
  logic [31:0] ctrl_numByte;
  logic        ctrl_busy;

  modport master (
    output ctrl_write,
    output ctrl_erase,
    output ctrl_address,
    output ctrl_numByte,
    input  ctrl_busy
  );

  modport slave (
    input  ctrl_write,
    input  ctrl_erase,
    input  ctrl_address,
    input  ctrl_numByte,
    output ctrl_busy
  );
endinterface

// File: rtl/flash_write_sequencer.sv
// Splits a bulk flash write into page programs, optionally erasing
// each touched sector first; one command in flight at a time.
module flash_write_sequencer #(
  parameter int PAGE_BYTES   = 256,
  parameter int SECTOR_BYTES = 4096,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic [31:0] total_len,
  input  logic        erase_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  flash_write_sequencer_if.master ctrl
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [23:0] PAGE_MASK = 24'(PAGE_BYTES - 1);
  localparam logic [23:0] SECT_MASK = 24'(SECTOR_BYTES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [32:0] ADDR_END = 33'h100_0000;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ERASE_ISSUE,
    ERASE_WAIT,
    WRITE_ISSUE,
    WRITE_WAIT,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic [23:0] cur_addr_q, cur_addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic        erase_en_q, erase_en_d;
  logic        first_q, first_d;
  logic        erased_q, erased_d;
  logic        seen_q, seen_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;
  logic        er_q, er_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] nbyte_q, nbyte_d;

  logic [32:0] end_addr;
  logic [31:0] room;
  logic [31:0] chunk;
  logic        want_erase;

  assign end_addr = {9'b0, cur_addr_q}
                  + {1'b0, remaining_q};
  assign room = 32'(PAGE_BYTES)
              - {8'b0, cur_addr_q & PAGE_MASK};
  assign chunk = (remaining_q < room) ? remaining_q : room;

  // Writes never cross a page, so a new sector is always entered
  // at its aligned start; erased_q blocks a repeat after the erase.
  assign want_erase = erase_en_q && !erased_q &&
    (first_q || (cur_addr_q & SECT_MASK) == '0);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    erase_en_d  = erase_en_q;
    first_d     = first_q;
    erased_d    = erased_q;
    seen_d      = seen_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    nbyte_d     = nbyte_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_d        = 1'b0;
    er_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          remaining_d = total_len;
          erase_en_d  = erase_en;
          first_d     = 1'b1;
          erased_d    = 1'b0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (remaining_q == '0) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (end_addr > ADDR_END) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (want_erase) begin
          er_d    = 1'b1;
          addr_d  = cur_addr_q & ~SECT_MASK;
          nbyte_d = '0;
          state_d = ERASE_ISSUE;
        end else begin
          wr_d    = 1'b1;
          addr_d  = cur_addr_q;
          nbyte_d = chunk;
          state_d = WRITE_ISSUE;
        end
      end
      ERASE_ISSUE: begin
        first_d  = 1'b0;
        erased_d = 1'b1;
        seen_d   = 1'b0;
        cnt_d    = CW'(1);
        state_d  = ERASE_WAIT;
      end
      WRITE_ISSUE: begin
        cur_addr_d  = cur_addr_q + nbyte_q[23:0];
        remaining_d = remaining_q - nbyte_q;
        erased_d    = 1'b0;
        seen_d      = 1'b0;
        cnt_d       = CW'(1);
        state_d     = WRITE_WAIT;
      end
      ERASE_WAIT, WRITE_WAIT: begin
        if (!seen_q) begin
          if (ctrl.ctrl_busy) begin
            seen_d = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (!ctrl.ctrl_busy) begin
          state_d = CHECK;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = !(state_d inside {IDLE, FINISH});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      erase_en_q  <= 1'b0;
      first_q     <= 1'b0;
      erased_q    <= 1'b0;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      er_q        <= 1'b0;
      addr_q      <= '0;
      nbyte_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      erase_en_q  <= erase_en_d;
      first_q     <= first_d;
      erased_q    <= erased_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      er_q        <= er_d;
      addr_q      <= addr_d;
      nbyte_q     <= nbyte_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign ctrl.ctrl_write   = wr_q;
  assign ctrl.ctrl_erase   = er_q;
  assign ctrl.ctrl_address = addr_q;
  assign ctrl.ctrl_numByte = nbyte_q;

endmodule

// File: tb/tb_flash_write_sequencer.sv
// Randomized bench for flash_write_sequencer against a byte-range
// reference model and a simple busy-handshake controller.
module tb_flash_write_sequencer;
  localparam int PAGE = 256;
  localparam int SECT = 4096;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] base_addr;
  logic [31:0] total_len;
  logic        erase_en;
  logic        busy;
  logic        done;
  logic        err;

  flash_write_sequencer_if bus();

  flash_write_sequencer #(
    .PAGE_BYTES(PAGE),
    .SECTOR_BYTES(SECT),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .total_len(total_len),
    .erase_en(erase_en),
    .busy(busy),
    .done(done),
    .err(err),
    .ctrl(bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  // {is_erase, address, numByte}
  logic [56:0] exp_q[$];

  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   pulse_cnt = 0;
  int   last_pls  = -100;
  int   first_pls = -1;
  int   end_cyc   = -1;
  logic busy_end  = 1'b0;

  bit stuck   = 1'b0;
  int dly_hi  = 3;
  int hold_hi = 4;
  int hold_lo = 1;

  // Expected command stream from the byte range alone.
  task automatic model(input logic [23:0] b,
                       input logic [31:0] l,
                       input logic e,
                       output bit xd,
                       output bit xe);
    longint a, r, sec, last_sec, n;
    exp_q.delete();
    xd = 1'b0;
    xe = 1'b0;
    if (l == 0) begin
      xd = 1'b1;
      return;
    end
    if (longint'(b) + longint'(l) > 64'h100_0000) begin
      xe = 1'b1;
      return;
    end
    a = longint'(b);
    r = longint'(l);
    last_sec = -1;
    while (r > 0) begin
      sec = a / SECT;
      if (e && sec != last_sec) begin
        exp_q.push_back({1'b1, 24'(sec * SECT), 32'd0});
        last_sec = sec;
      end
      n = PAGE - (a % PAGE);
      if (n > r) n = r;
      exp_q.push_back({1'b0, 24'(a), 32'(n)});
      a += n;
      r -= n;
    end
    xd = 1'b1;
  endtask

  initial begin
    bus.ctrl_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && !stuck &&
          (bus.ctrl_write || bus.ctrl_erase)) begin
        repeat ($urandom_range(dly_hi, 1)) @(posedge clk);
        #1 bus.ctrl_busy = 1'b1;
        repeat ($urandom_range(hold_hi, hold_lo))
          @(posedge clk);
        #1 bus.ctrl_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.ctrl_write || bus.ctrl_erase) begin
          chk("exclusive",
              64'(bus.ctrl_write & bus.ctrl_erase), 64'd0);
          chk("pulse_gap", 64'(cyc - last_pls >= 2), 64'd1);
          last_pls = cyc;
          pulse_cnt++;
          if (first_pls < 0) first_pls = cyc;
          if (exp_q.size() == 0)
            chk("extra_cmd", 64'({1'b1, bus.ctrl_erase,
                bus.ctrl_address, bus.ctrl_numByte}), 64'd0);
          else
            chk("cmd", 64'({bus.ctrl_erase, bus.ctrl_address,
                bus.ctrl_numByte}), 64'(exp_q.pop_front()));
        end
        if (done || err) begin
          end_cyc  = cyc;
          busy_end = busy;
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
      end
    end
  end

  task automatic kick(input logic [23:0] b,
                      input logic [31:0] l,
                      input logic e,
                      output int n);
    first_pls = -1;
    @(negedge clk);
    n = cyc;
    start     = 1'b1;
    base_addr = b;
    total_len = l;
    erase_en  = e;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 24'($urandom);
    total_len = $urandom;
    erase_en  = 1'($urandom);
    chk("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic run_txn(input logic [23:0] b,
                         input logic [31:0] l,
                         input logic e,
                         input bit stk,
                         input string tag);
    bit xd, xe, ovf;
    int d0, e0, n;
    model(b, l, e, xd, xe);
    ovf = xe;
    if (stk) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      xd = 1'b0;
      xe = 1'b1;
    end
    stuck = stk;
    d0 = done_cnt;
    e0 = err_cnt;
    kick(b, l, e, n);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (done_cnt != d0 || err_cnt != e0) break;
    end
    repeat (4) @(negedge clk);
    chk({tag, "/one_end"},
        64'((done_cnt - d0) + (err_cnt - e0)), 64'd1);
    chk({tag, "/done"}, 64'(done_cnt - d0), 64'(xd));
    chk({tag, "/err"}, 64'(err_cnt - e0), 64'(xe));
    chk({tag, "/cmds_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "/busy_at_end"}, 64'(busy_end), 64'd0);
    if (l == 0 || ovf)
      chk({tag, "/end_lat"}, 64'(end_cyc - n), 64'd2);
    else
      chk({tag, "/first_lat"}, 64'(first_pls - n), 64'd2);
    if (stk)
      chk({tag, "/tmo_lat"},
          64'(end_cyc - first_pls), 64'(TMO));
    exp_q.delete();
    stuck = 1'b0;
  endtask

  task automatic reset_abort();
    bit xd, xe;
    int d0, e0, p0, n;
    model(24'h000400, 32'd2000, 1'b0, xd, xe);
    d0 = done_cnt;
    e0 = err_cnt;
    p0 = pulse_cnt;
    kick(24'h000400, 32'd2000, 1'b0, n);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (pulse_cnt >= p0 + 3) break;
    end
    chk("rst/three_cmds", 64'(pulse_cnt - p0), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk("rst/outputs", 64'({busy, done, err,
        bus.ctrl_write, bus.ctrl_erase}), 64'd0);
    chk("rst/cmd_bus", 64'({bus.ctrl_address,
        bus.ctrl_numByte}), 64'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst/no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst/no_err", 64'(err_cnt - e0), 64'd0);
    chk("rst/idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [23:0] b;
    logic [31:0] l;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    total_len = '0;
    erase_en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/outputs", 64'({busy, done, err,
        bus.ctrl_write, bus.ctrl_erase}), 64'd0);
    chk("reset/cmd_bus", 64'({bus.ctrl_address,
        bus.ctrl_numByte}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    dly_hi  = 1;
    hold_lo = 50;
    hold_hi = 50;
    run_txn(24'h000000, 32'd5000, 1'b0, 1'b0, "len5000");
    hold_lo = 1;
    hold_hi = 4;
    dly_hi  = 3;
    run_txn(24'h0000F0, 32'd300, 1'b0, 1'b0, "unaligned");
    run_txn(24'h000FF0, 32'd32, 1'b1, 1'b0, "erase_cross");
    run_txn(24'h001234, 32'd0, 1'b1, 1'b0, "len0");
    run_txn(24'hFFFF00, 32'h200, 1'b0, 1'b0, "overflow");
    run_txn(24'hFFFF00, 32'h100, 1'b1, 1'b0, "top_wrap");
    run_txn(24'h000300, 32'd600, 1'b0, 1'b1, "stuck");
    run_txn(24'h000300, 32'd600, 1'b0, 1'b0, "after_stuck");
    reset_abort();
    run_txn(24'h020080, 32'd700, 1'b1, 1'b0, "after_rst");

    for (int t = 0; t < 30; t++) begin
      b = 24'($urandom);
      if ($urandom_range(3, 0) == 0)
        b = 24'hFFFFFF - 24'($urandom_range(2000, 0));
      l = $urandom_range(1200, 0);
      if ($urandom_range(7, 0) == 0) l = 0;
      dly_hi  = $urandom_range(4, 1);
      hold_hi = $urandom_range(6, 1);
      run_txn(b, l, 1'($urandom), 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
